// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response handshake between the fetch stage and imem.
// One outstanding request: req/addr qualified by ready, data returned on rvalid.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues single-outstanding imem fetches at pc_in, fills
// the IF/ID register, throttles the PC adder via pc_stop and squashes on jump_start.
module fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  pc_in,
  input  logic         jump_start,
  input  logic         id_stall,
  fetch_unit_if.master imem,
  output logic         pc_stop,
  output logic         if_valid,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] req_pc;
  logic [31:0] buf_instr;
  logic        discard;
  logic        slot_free;
  logic        wait_commit;
  logic        hold_commit;

  assign slot_free = !if_valid || !id_stall;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; the asynchronous reset clears all of it, no edge required.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: each combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = REQ;
      REQ:  if (imem.ready) state_nx = WAIT;
      WAIT: if (imem.rvalid) state_nx = (jump_start || discard || slot_free) ? REQ : HOLD;
      HOLD: if (jump_start || !id_stall) state_nx = REQ;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    imem.req    = (state == REQ);
    imem.addr   = (state == REQ) ? {pc_in[31:2], 2'b00} : 32'h0;
    wait_commit = (state == WAIT) && imem.rvalid && !discard && slot_free && !jump_start;
    hold_commit = (state == HOLD) && !id_stall && !jump_start;
    // PC advances once per committed instruction or flushed fetch, never otherwise.
    pc_stop     = !(wait_commit || hold_commit || jump_start);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard   <= 1'b0;
      req_pc    <= 32'h0;
      buf_instr <= 32'h0;
    end else begin
      if (state == REQ && imem.ready) begin
        req_pc  <= {pc_in[31:2], 2'b00};
        // A jump during acceptance orphans the response that is now in flight.
        discard <= jump_start;
      end else if (state == WAIT) begin
        if (imem.rvalid)     discard <= 1'b0;
        else if (jump_start) discard <= 1'b1;
      end
      if (state == WAIT && imem.rvalid && !discard && !slot_free && !jump_start)
        buf_instr <= imem.rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= 32'h0;
    end else if (jump_start) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (wait_commit) begin
      if_valid <= 1'b1;
      if_instr <= imem.rdata;
      if_pc    <= req_pc;
    end else if (hold_commit) begin
      if_valid <= 1'b1;
      if_instr <= buf_instr;
      if_pc    <= req_pc;
    end else if (!id_stall) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the PC adder. Each cycle it takes the current `pc_in` and issues a single-outstanding request to instruction memory over a req/ready + rvalid handshake. It then captures the returned word into the IF/ID pipeline register for decode. It drives `pc_stop` back to the PC adder so the PC advances only when an instruction is committed into IF/ID, and it squashes in-flight fetches on `jump_start`.

## Interface
- NOP_INSTR, 32'h0000_0000, bubble word driven on `if_instr` when invalid or flushed
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- pc_in  in  32  current PC from PC adder
- jump_start  in  1  branch taken; flush fetch and IF/ID
- id_stall  in  1  decode cannot accept; hold IF/ID
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word address, {pc_in[31:2],2'b00}
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- pc_stop  out  1  hold PC adder (combinational)
- if_valid  out  1  IF/ID holds a live instruction
- if_instr  out  32  IF/ID instruction
- if_pc  out  32  PC of if_instr

## Operation
- States: IDLE, REQ, WAIT, HOLD. There is one outstanding request at most. Internal regs: req_pc[31:0], buf_instr[31:0], discard.
- IDLE: entered on reset. Moves to REQ on the first clock after reset deasserts.
- REQ: `imem_req`=1 and `imem_addr`=aligned `pc_in`. If `imem_ready`=1, latch req_pc<=aligned pc_in and go to WAIT. Otherwise stay in REQ.
- WAIT: `imem_req`=0. Wait for `imem_rvalid`.
  - If discard=1: drop the data, clear discard, go to REQ.
  - If the slot is free (if_valid=0 or id_stall=0): if_instr<=imem_rdata, if_pc<=req_pc, if_valid<=1, go to REQ.
  - Otherwise: buf_instr<=imem_rdata, go to HOLD.
- HOLD: when id_stall=0, move buf_instr/req_pc into IF/ID, if_valid<=1, go to REQ.
- IF/ID drain: if id_stall=0 and no load occurs this cycle, if_valid<=0 and if_instr<=NOP_INSTR. If id_stall=1, IF/ID holds its value.
- pc_stop is 0 only in these cases:
  - A commit cycle: WAIT with rvalid, discard=0, and slot free; or HOLD with id_stall=0.
  - jump_start=1.
  - In all other cycles pc_stop is 1.
- jump_start=1 has priority over everything and does all of the following:
  - if_valid<=0 and if_instr<=NOP_INSTR, regardless of id_stall.
  - REQ with imem_ready=1: go to WAIT with discard<=1.
  - REQ with imem_ready=0: stay in REQ.
  - WAIT with rvalid=0: set discard<=1.
  - WAIT with rvalid=1: drop the data and go to REQ.
  - HOLD: drop buf_instr and go to REQ.
  - IDLE: unaffected.
- Address bits pc_in[1:0] are ignored.

## Timing
- Reset values:
  - State IDLE.
  - imem_req=0, imem_addr=0.
  - pc_stop=1.
  - if_valid=0, if_instr=NOP_INSTR, if_pc=0.
  - discard=0, req_pc=0, buf_instr=0.
- Reset asserted mid-operation aborts immediately. Any later rvalid belonging to the aborted request is the memory's responsibility to suppress.
- Best case with ready=1 in REQ and rvalid in the next cycle: one instruction every 2 cycles.
  - Cycle n: REQ, accept.
  - Cycle n+1: WAIT, rvalid, pc_stop=0.
  - Edge n+1→n+2: if_valid=1 and the PC advances.
  - Cycle n+2: REQ at the new PC.
- Fetch-to-IF/ID latency is 1 edge after rvalid.
- pc_stop is combinational from state, imem_rvalid, id_stall and jump_start. It has no dependency on pc_in.
- imem_addr and imem_req are combinational from state and pc_in. They must be held stable while in REQ, which is satisfied because pc_stop=1 holds pc_in.
- The PC adder advances exactly once per committed or flushed fetch, never twice for one instruction.

## Test plan
- Reset release with pc_in=0, imem_ready=1, rvalid one cycle after accept, id_stall=0. Required: fetches at imem_addr 0, 4, 8; if_pc=0, 4, 8 on consecutive 2-cycle intervals; pc_stop low exactly one cycle in each pair.
- imem_ready held low for 3 cycles at pc_in=32'h10. Required: imem_req stays 1, imem_addr=32'h10 throughout, pc_stop=1; the fetch proceeds after ready rises.
- id_stall=1 while if_valid=1 and a new rvalid arrives (rdata=32'hDEAD_BEEF). Required: state goes to HOLD, if_instr unchanged, pc_stop=1. After id_stall drops: if_instr=32'hDEAD_BEEF the next edge, pc_stop=0 for that cycle.
- jump_start in WAIT with no rvalid, then rvalid arrives 2 cycles later. Required: if_valid=0 and if_instr=NOP_INSTR after the jump edge; the returned data is discarded; the next request uses the new pc_in.
- jump_start in the same cycle as rvalid, and jump_start in HOLD. Required: no instruction enters IF/ID, pc_stop=0 in the jump cycle, state goes to REQ.
- Reset asserted in WAIT. Required: all outputs at reset values immediately, with no clock edge needed.
